// File: rtl/uart_tx_serializer.sv
// rtl/uart_tx_serializer.sv - FIFO-buffered 8N1 UART transmitter with divisor-timed bits
module uart_tx_serializer #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic [15:0]           i_divisor,
    input  logic [7:0]            i_tx,
    input  logic                  i_tx_stb,
    output logic                  o_txd,
    output logic                  o_thr_empty,
    output logic                  o_tx_empty,
    output logic                  o_full,
    output logic [DEPTH_LOG2:0]   o_level,
    output logic                  o_overflow
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_LEVEL = {1'b1, {DEPTH_LOG2{1'b0}}};

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t                 state, state_n;
    logic [7:0]             mem [DEPTH];
    logic [DEPTH_LOG2-1:0]  wr_ptr, rd_ptr;
    logic [DEPTH_LOG2:0]    level;
    logic [7:0]             shift, shift_n;
    logic [2:0]             bit_idx, bit_idx_n;
    logic [15:0]            timer, timer_n;
    logic [15:0]            latched_div, latched_div_n;
    logic                   txd_n;
    logic                   push;
    logic                   pop;
    logic                   bit_end;

    assign o_full      = (level == FULL_LEVEL);
    assign o_level     = level;
    assign o_thr_empty = (level == '0);
    assign o_tx_empty  = o_thr_empty && (state == IDLE);

    // Uses the registered full flag, so a push at full is dropped even alongside a pop.
    assign push    = i_tx_stb && !o_full;
    assign bit_end = (timer == 16'd0);

    always_ff @(posedge i_clk) begin
        if (i_reset_n && push) begin
            mem[wr_ptr] <= i_tx;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            o_overflow <= 1'b0;
        end else begin
            o_overflow <= i_tx_stb && o_full;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state       <= IDLE;
            shift       <= '0;
            bit_idx     <= '0;
            timer       <= '0;
            latched_div <= '0;
            o_txd       <= 1'b1;
        end else begin
            state       <= state_n;
            shift       <= shift_n;
            bit_idx     <= bit_idx_n;
            timer       <= timer_n;
            latched_div <= latched_div_n;
            o_txd       <= txd_n;
        end
    end

    always_comb begin
        state_n       = state;
        shift_n       = shift;
        bit_idx_n     = bit_idx;
        timer_n       = timer;
        latched_div_n = latched_div;
        pop           = 1'b0;
        txd_n         = 1'b1;

        case (state)
            IDLE: begin
                if (!o_thr_empty) begin
                    pop           = 1'b1;
                    shift_n       = mem[rd_ptr];
                    latched_div_n = i_divisor;
                    timer_n       = (i_divisor == 16'd0) ? 16'd0 : i_divisor - 16'd1;
                    state_n       = START;
                end
            end
            START: begin
                if (bit_end) begin
                    timer_n   = (latched_div == 16'd0) ? 16'd0 : latched_div - 16'd1;
                    bit_idx_n = 3'd0;
                    state_n   = DATA;
                end else begin
                    timer_n = timer - 16'd1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    timer_n   = (latched_div == 16'd0) ? 16'd0 : latched_div - 16'd1;
                    shift_n   = {1'b0, shift[7:1]};
                    bit_idx_n = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
                        state_n = STOP;
                    end
                end else begin
                    timer_n = timer - 16'd1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    // Chain straight into the next start bit when more data is queued.
                    if (!o_thr_empty) begin
                        pop           = 1'b1;
                        shift_n       = mem[rd_ptr];
                        latched_div_n = i_divisor;
                        timer_n       = (i_divisor == 16'd0) ? 16'd0 : i_divisor - 16'd1;
                        state_n       = START;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    timer_n = timer - 16'd1;
                end
            end
            default: state_n = IDLE;
        endcase

        // The line register follows the state being entered so it changes on the same edge.
        case (state_n)
            START:   txd_n = 1'b0;
            DATA:    txd_n = shift_n[0];
            default: txd_n = 1'b1;
        endcase
    end
endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb/tb_uart_tx_serializer.sv - scoreboard bench decoding serial frames from uart_tx_serializer
module tb_uart_tx_serializer;
    logic        i_clk;
    logic        i_reset_n;
    logic [15:0] i_divisor;
    logic [7:0]  i_tx;
    logic        i_tx_stb;
    logic        o_txd;
    logic        o_thr_empty;
    logic        o_tx_empty;
    logic        o_full;
    logic [4:0]  o_level;
    logic        o_overflow;

    typedef struct {
        logic [7:0]  data;
        logic [15:0] div;
    } exp_t;

    exp_t sb[$];
    int   start_log[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    int   frames   = 0;

    uart_tx_serializer #(.DEPTH_LOG2(4)) dut (
        .i_clk       (i_clk),
        .i_reset_n   (i_reset_n),
        .i_divisor   (i_divisor),
        .i_tx        (i_tx),
        .i_tx_stb    (i_tx_stb),
        .o_txd       (o_txd),
        .o_thr_empty (o_thr_empty),
        .o_tx_empty  (o_tx_empty),
        .o_full      (o_full),
        .o_level     (o_level),
        .o_overflow  (o_overflow)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic push_byte(input logic [7:0] b, input logic [15:0] d, input bit expect_tx);
        i_tx     = b;
        i_tx_stb = 1'b1;
        if (expect_tx) begin
            exp_t e;
            e.data = b;
            e.div  = d;
            sb.push_back(e);
        end
        @(posedge i_clk);
        #1;
        i_tx_stb = 1'b0;
    endtask

    // Counts edges until o_tx_empty rises; optionally rewrites the divisor part way through.
    task automatic measure(input string tag, input int exp_n, input int chg_at, input logic [15:0] chg_div);
        int n;
        int w;
        w = 0;
        while (o_txd && w < 100) begin
            @(posedge i_clk);
            #1;
            w++;
        end
        n = 0;
        while (!o_tx_empty && n < 20000) begin
            @(posedge i_clk);
            #1;
            n++;
            if (n == chg_at) i_divisor = chg_div;
        end
        check(tag, n, exp_n);
    endtask

    // Frame monitor: decodes each frame cycle-by-cycle against the scoreboard head.
    initial begin
        logic       prev;
        logic [9:0] bits;
        logic [9:0] exp_bits;
        logic       unstable;
        logic       aborted;
        int         d;
        prev = 1'b1;
        forever begin
            @(negedge i_clk);
            if (i_reset_n && prev && !o_txd) begin
                start_log.push_back(cyc);
                frames++;
                if (sb.size() == 0) begin
                    check("unexpected_frame", 1, 0);
                end else begin
                    d        = (sb[0].div == 16'd0) ? 1 : int'(sb[0].div);
                    unstable = 1'b0;
                    aborted  = 1'b0;
                    bits     = '0;
                    for (int k = 0; k < 10 && !aborted; k++) begin
                        for (int j = 0; j < d && !aborted; j++) begin
                            if (k > 0 || j > 0) @(negedge i_clk);
                            if (!i_reset_n) begin
                                aborted = 1'b1;
                            end else if (j == 0) begin
                                bits[k] = o_txd;
                            end else if (o_txd !== bits[k]) begin
                                unstable = 1'b1;
                            end
                        end
                    end
                    if (!aborted) begin
                        exp_bits = {1'b1, sb[0].data, 1'b0};
                        void'(sb.pop_front());
                        check("frame_bits", {22'd0, bits}, {22'd0, exp_bits});
                        check("frame_bit_width", {31'd0, unstable}, 32'd0);
                    end
                end
            end
            prev = o_txd;
        end
    end

    initial begin
        int idx;
        bit hi_ok;
        int frames_before;

        i_reset_n = 1'b0;
        i_divisor = 16'd4;
        i_tx      = 8'h00;
        i_tx_stb  = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        check("rst_txd", o_txd, 1);
        check("rst_thr_empty", o_thr_empty, 1);
        check("rst_tx_empty", o_tx_empty, 1);
        check("rst_full", o_full, 0);
        check("rst_level", o_level, 0);
        check("rst_overflow", o_overflow, 0);
        i_reset_n = 1'b1;
        repeat (2) @(posedge i_clk);
        #1;

        // Single byte, divisor 4
        push_byte(8'hA5, 16'd4, 1);
        check("lat_level_e0", o_level, 1);
        check("lat_thr_empty_e0", o_thr_empty, 0);
        check("lat_tx_empty_e0", o_tx_empty, 0);
        @(posedge i_clk);
        #1;
        check("lat_txd_e1", o_txd, 0);
        check("lat_level_e1", o_level, 0);
        check("lat_thr_empty_e1", o_thr_empty, 1);
        measure("single_frame_len", 40, -1, 16'd0);
        check("single_sb_drained", sb.size(), 0);

        // Back-to-back, divisor 2
        i_divisor = 16'd2;
        idx = start_log.size();
        push_byte(8'h00, 16'd2, 1);
        push_byte(8'hFF, 16'd2, 1);
        measure("b2b_total_len", 40, -1, 16'd0);
        check("b2b_frames_seen", start_log.size(), idx + 2);
        if (start_log.size() >= idx + 2) check("b2b_no_gap", start_log[idx+1] - start_log[idx], 20);
        check("b2b_sb_drained", sb.size(), 0);

        // Overflow, divisor 1000 for the first frame then 1
        i_divisor = 16'd1000;
        for (int i = 0; i < 17; i++) begin
            push_byte(8'h10 + 8'(i), (i == 0) ? 16'd1000 : 16'd1, 1);
        end
        check("ovf_full", o_full, 1);
        check("ovf_level", o_level, 16);
        check("ovf_no_pulse_yet", o_overflow, 0);
        push_byte(8'hEE, 16'd1, 0);
        check("ovf_pulse", o_overflow, 1);
        check("ovf_level_kept", o_level, 16);
        @(posedge i_clk);
        #1;
        check("ovf_pulse_one_cycle", o_overflow, 0);
        i_divisor = 16'd1;
        measure("ovf_drain_len", 10143, -1, 16'd0);
        check("ovf_sb_drained", sb.size(), 0);

        // Divisor 0 behaves as 1
        i_divisor = 16'd0;
        push_byte(8'h3C, 16'd0, 1);
        measure("div0_frame_len", 10, -1, 16'd0);
        check("div0_sb_drained", sb.size(), 0);

        // Divisor change during frame 1 affects only frame 2
        i_divisor = 16'd8;
        idx = start_log.size();
        push_byte(8'h96, 16'd8, 1);
        push_byte(8'h4B, 16'd3, 1);
        measure("divchg_total_len", 110, 24, 16'd3);
        if (start_log.size() >= idx + 2) check("divchg_frame1_len", start_log[idx+1] - start_log[idx], 80);
        else check("divchg_frames_seen", start_log.size(), idx + 2);
        check("divchg_sb_drained", sb.size(), 0);

        // Reset during data bit 4 with 3 bytes queued
        i_divisor = 16'd4;
        push_byte(8'h5A, 16'd4, 1);
        push_byte(8'h77, 16'd4, 1);
        push_byte(8'h81, 16'd4, 1);
        repeat (20) begin
            @(posedge i_clk);
            #1;
        end
        i_reset_n = 1'b0;
        @(posedge i_clk);
        #1;
        i_reset_n = 1'b1;
        sb.delete();
        frames_before = frames;
        check("rstmid_txd", o_txd, 1);
        check("rstmid_level", o_level, 0);
        check("rstmid_thr_empty", o_thr_empty, 1);
        check("rstmid_tx_empty", o_tx_empty, 1);
        hi_ok = 1'b1;
        repeat (200) begin
            @(posedge i_clk);
            #1;
            if (!o_txd) hi_ok = 1'b0;
        end
        check("rstmid_line_idle", hi_ok, 1);
        check("rstmid_no_frames", frames, frames_before);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
